// File: rtl/mem_access_arbiter_if.sv
// External memory bus between mem_access_arbiter (master) and the memory controller (slave).
interface mem_access_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              bus_req;
   logic              bus_we;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;
   logic [3:0]        bus_sel;
   logic              bus_ack;
   logic [DATA_W-1:0] bus_rdata;
   logic              bus_timeout;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wdata, bus_sel, bus_timeout,
      input  bus_ack, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wdata, bus_sel, bus_timeout,
      output bus_ack, bus_rdata
   );
endinterface

// File: rtl/mem_access_arbiter.sv
// Shares one memory bus between instruction fetch and load/store, data first.
// Optional bus-wait watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_access_arbiter #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 if_req,
   input  logic [ADDR_W-1:0]    if_addr,
   output logic [DATA_W-1:0]    if_rdata,
   output logic                 if_done,
   input  logic                 d_read,
   input  logic                 d_write,
   input  logic                 d_byte,
   input  logic [ADDR_W-1:0]    d_addr,
   input  logic [DATA_W-1:0]    d_wdata,
   output logic [DATA_W-1:0]    d_rdata,
   output logic                 d_done,
   output logic                 stall,
   mem_access_arbiter_if.master bus
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      DATA_WAIT  = 2'd1,
      FETCH_WAIT = 2'd2,
      RESP       = 2'd3
   } state_t;

   if (DATA_W != 32 || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("mem_access_arbiter: DATA_W must be 32 and TIMEOUT_CYCLES at least 1");
   end

   function automatic logic [3:0] lane_sel(input logic byte_acc, input logic [1:0] off);
      logic [3:0] sel;
      if (byte_acc) begin
         sel = 4'b0001 << off;
      end else begin
         sel = 4'b1111;
      end
      return sel;
   endfunction

   function automatic logic [DATA_W-1:0] pack_wdata(input logic byte_acc,
                                                    input logic [DATA_W-1:0] wdata);
      logic [DATA_W-1:0] packed_w;
      if (byte_acc) begin
         packed_w = {4{wdata[7:0]}};
      end else begin
         packed_w = wdata;
      end
      return packed_w;
   endfunction

   // Byte loads return the addressed lane zero-extended; sign extension is downstream.
   function automatic logic [DATA_W-1:0] unpack_rdata(input logic byte_acc,
                                                      input logic [1:0] off,
                                                      input logic [DATA_W-1:0] rdata);
      logic [7:0] lane;
      case (off)
         2'd0:    lane = rdata[7:0];
         2'd1:    lane = rdata[15:8];
         2'd2:    lane = rdata[23:16];
         2'd3:    lane = rdata[31:24];
         default: lane = 8'h00;
      endcase
      if (byte_acc) begin
         return {{(DATA_W-8){1'b0}}, lane};
      end else begin
         return rdata;
      end
   endfunction

   state_t            state_r;
   logic              req_r;
   logic              we_r;
   logic [ADDR_W-1:0] addr_r;
   logic [DATA_W-1:0] wdata_r;
   logic [3:0]        sel_r;
   logic              byte_r;
   logic [1:0]        off_r;
   logic              in_wait_s;
   logic              tmo_hit_s;

   assign in_wait_s = (state_r == DATA_WAIT) || (state_r == FETCH_WAIT);

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_r;
   logic             timeout_r;

   // Hit on the wait cycle that would bring the ack-less count up to the limit.
   assign tmo_hit_s = (cnt_r == CNT_LAST);

   // Wait-cycle counter (cleared in IDLE, so every WAIT entry starts from zero) and error pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r     <= {CNT_W{1'b0}};
         timeout_r <= 1'b0;
      end else begin
         timeout_r <= in_wait_s && !bus.bus_ack && tmo_hit_s;
         if (!in_wait_s) begin
            cnt_r <= {CNT_W{1'b0}};
         end else if (!bus.bus_ack) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

   assign bus.bus_timeout = timeout_r;
`else
   assign tmo_hit_s       = 1'b0;
   assign bus.bus_timeout = 1'b0;
`endif

   // Arbitration FSM: grant, hold the bus cycle until ack, capture data, pulse done.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= IDLE;
         req_r    <= 1'b0;
         we_r     <= 1'b0;
         addr_r   <= {ADDR_W{1'b0}};
         wdata_r  <= {DATA_W{1'b0}};
         sel_r    <= 4'b0000;
         byte_r   <= 1'b0;
         off_r    <= 2'b00;
         if_rdata <= {DATA_W{1'b0}};
         d_rdata  <= {DATA_W{1'b0}};
         if_done  <= 1'b0;
         d_done   <= 1'b0;
      end else begin
         if_done <= 1'b0;
         d_done  <= 1'b0;
         case (state_r)
            IDLE: begin
               if (d_read || d_write) begin
                  req_r   <= 1'b1;
                  we_r    <= d_write;
                  addr_r  <= {d_addr[ADDR_W-1:2], 2'b00};
                  sel_r   <= lane_sel(d_byte, d_addr[1:0]);
                  wdata_r <= pack_wdata(d_byte, d_wdata);
                  byte_r  <= d_byte;
                  off_r   <= d_addr[1:0];
                  state_r <= DATA_WAIT;
               end else if (if_req) begin
                  req_r   <= 1'b1;
                  we_r    <= 1'b0;
                  addr_r  <= if_addr;
                  sel_r   <= 4'b1111;
                  wdata_r <= {DATA_W{1'b0}};
                  state_r <= FETCH_WAIT;
               end else begin
                  state_r <= IDLE;
               end
            end
            DATA_WAIT: begin
               if (bus.bus_ack) begin
                  req_r   <= 1'b0;
                  d_done  <= 1'b1;
                  if (!we_r) begin
                     d_rdata <= unpack_rdata(byte_r, off_r, bus.bus_rdata);
                  end else begin
                     d_rdata <= d_rdata;
                  end
                  state_r <= RESP;
               end else if (tmo_hit_s) begin
                  req_r   <= 1'b0;
                  d_done  <= 1'b1;
                  d_rdata <= {DATA_W{1'b0}};
                  state_r <= RESP;
               end else begin
                  state_r <= DATA_WAIT;
               end
            end
            FETCH_WAIT: begin
               if (bus.bus_ack) begin
                  req_r    <= 1'b0;
                  if_done  <= 1'b1;
                  if_rdata <= bus.bus_rdata;
                  state_r  <= RESP;
               end else if (tmo_hit_s) begin
                  req_r    <= 1'b0;
                  if_done  <= 1'b1;
                  if_rdata <= {DATA_W{1'b0}};
                  state_r  <= RESP;
               end else begin
                  state_r <= FETCH_WAIT;
               end
            end
            // One idle cycle with done high lets the requester drop its level request.
            RESP: begin
               state_r <= IDLE;
            end
            default: begin
               req_r   <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign bus.bus_req   = req_r;
   assign bus.bus_we    = we_r;
   assign bus.bus_addr  = addr_r;
   assign bus.bus_wdata = wdata_r;
   assign bus.bus_sel   = sel_r;

   assign stall = ((d_read | d_write) & ~d_done) | (if_req & ~if_done);

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Scoreboard bench for mem_access_arbiter: directed transfers queue their expected bus cycle
// and completion; a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_access_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_done;
   logic        d_read;
   logic        d_write;
   logic        d_byte;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_done;
   logic        stall;

`ifdef MEM_TIMEOUT_EN
   localparam int TMO = 4;
`else
   localparam int TMO = 255;
`endif

   mem_access_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mb ();

   mem_access_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
      .clk      (clk),
      .rst      (rst),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_rdata (if_rdata),
      .if_done  (if_done),
      .d_read   (d_read),
      .d_write  (d_write),
      .d_byte   (d_byte),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_rdata  (d_rdata),
      .d_done   (d_done),
      .stall    (stall),
      .bus      (mb)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  sel;
   } bus_exp_t;

   typedef struct packed {
      logic        is_data;
      logic [31:0] rdata;
      logic        tmo;
   } done_exp_t;

   bus_exp_t  bus_q[$];
   done_exp_t done_q[$];
   int        errors = 0;
   int        checks = 0;
   int        stall_cnt = 0;
   logic      prev_req = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare each new bus cycle and each completion against the queues.
   always @(negedge clk) begin
      bus_exp_t  be;
      done_exp_t de;
      if (stall) stall_cnt++;
      if (mb.bus_req && !prev_req) begin
         if (bus_q.size() == 0) begin
            check("bus_unexpected", {31'd0, mb.bus_req}, 32'd0);
         end else begin
            be = bus_q.pop_front();
            check("bus_addr", mb.bus_addr, be.addr);
            check("bus_sel", {28'd0, mb.bus_sel}, {28'd0, be.sel});
            check("bus_we", {31'd0, mb.bus_we}, {31'd0, be.we});
            if (be.we) check("bus_wdata", mb.bus_wdata, be.wdata);
         end
      end
      prev_req = mb.bus_req;
      if (if_done && d_done) check("done_both", {30'd0, if_done, d_done}, 32'd0);
      if (if_done || d_done) begin
         if (done_q.size() == 0) begin
            check("done_unexpected", {30'd0, if_done, d_done}, 32'd0);
         end else begin
            de = done_q.pop_front();
            check("done_kind", {31'd0, d_done}, {31'd0, de.is_data});
            check("done_rdata", de.is_data ? d_rdata : if_rdata, de.rdata);
            check("done_timeout", {31'd0, mb.bus_timeout}, {31'd0, de.tmo});
         end
      end else if (mb.bus_timeout) begin
         check("timeout_alone", {31'd0, mb.bus_timeout}, 32'd0);
      end
   end

   task automatic expect_bus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] sel);
      bus_exp_t e;
      e.we = we; e.addr = addr; e.wdata = wdata; e.sel = sel;
      bus_q.push_back(e);
   endtask

   task automatic expect_done(input logic is_data, input logic [31:0] rdata, input logic tmo);
      done_exp_t e;
      e.is_data = is_data; e.rdata = rdata; e.tmo = tmo;
      done_q.push_back(e);
   endtask

   task automatic run_xfer(input string name, input bit is_data, input bit rd, input bit wr,
                           input bit byt, input logic [31:0] addr, input logic [31:0] wdata,
                           input int waits, input logic [31:0] ack_data,
                           input logic [31:0] e_addr, input logic [3:0] e_sel, input bit e_we,
                           input logic [31:0] e_wdata, input logic [31:0] e_rdata);
      int t;
      expect_bus(e_we, e_addr, e_wdata, e_sel);
      expect_done(is_data, e_rdata, 1'b0);
      stall_cnt = 0;
      if (is_data) begin
         d_read = rd; d_write = wr; d_byte = byt; d_addr = addr; d_wdata = wdata;
      end else begin
         if_req = 1'b1; if_addr = addr;
      end
      t = 0;
      do begin
         tick();
         t++;
      end while (!mb.bus_req && t < 20);
      check({name, "_grant_latency"}, t, 32'd1);
      repeat (waits) tick();
      mb.bus_ack = 1'b1; mb.bus_rdata = ack_data;
      tick();
      mb.bus_ack = 1'b0; mb.bus_rdata = 32'h0;
      check({name, "_done"}, {31'd0, is_data ? d_done : if_done}, 32'd1);
      check({name, "_stall_in_done"}, {31'd0, stall}, 32'd0);
      d_read = 1'b0; d_write = 1'b0; d_byte = 1'b0; if_req = 1'b0;
      tick();
      check({name, "_done_once"}, {30'd0, if_done, d_done}, 32'd0);
      check({name, "_stall_cycles"}, stall_cnt, 2 + waits);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int bad;
      rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; d_read = 1'b0; d_write = 1'b0;
      d_byte = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
      mb.bus_ack = 1'b0; mb.bus_rdata = 32'h0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("rst_bus_req", {31'd0, mb.bus_req}, 32'd0);
      check("rst_bus_fields", {mb.bus_we, mb.bus_sel} , 32'd0);
      check("rst_bus_addr", mb.bus_addr | mb.bus_wdata, 32'd0);
      check("rst_rdata", if_rdata | d_rdata, 32'd0);
      check("rst_pulses", {29'd0, if_done, d_done, mb.bus_timeout}, 32'd0);

      run_xfer("fetch",   1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 0, 32'h00A00093,
               32'h100, 4'b1111, 1'b0, 32'h0, 32'h00A00093);
      run_xfer("sb",      1'b1, 1'b0, 1'b1, 1'b1, 32'h203, 32'h0000005A, 0, 32'hDEADBEEF,
               32'h200, 4'b1000, 1'b1, 32'h5A5A5A5A, 32'h0);
      run_xfer("lb1",     1'b1, 1'b1, 1'b0, 1'b1, 32'h401, 32'h0, 3, 32'h11223344,
               32'h400, 4'b0010, 1'b0, 32'h0, 32'h00000033);
      run_xfer("lw",      1'b1, 1'b1, 1'b0, 1'b0, 32'h80C, 32'h0, 1, 32'hCAFEF00D,
               32'h80C, 4'b1111, 1'b0, 32'h0, 32'hCAFEF00D);
      run_xfer("sw",      1'b1, 1'b0, 1'b1, 1'b0, 32'h812, 32'h12345678, 2, 32'h0,
               32'h810, 4'b1111, 1'b1, 32'h12345678, 32'hCAFEF00D);
      run_xfer("rdwr",    1'b1, 1'b1, 1'b1, 1'b1, 32'h300, 32'h000000A7, 0, 32'hFFFFFFFF,
               32'h300, 4'b0001, 1'b1, 32'hA7A7A7A7, 32'hCAFEF00D);
      run_xfer("lb3",     1'b1, 1'b1, 1'b0, 1'b1, 32'h403, 32'h0, 0, 32'h11223344,
               32'h400, 4'b1000, 1'b0, 32'h0, 32'h00000011);
      run_xfer("lb2",     1'b1, 1'b1, 1'b0, 1'b1, 32'h402, 32'h0, 0, 32'hA1B2C3D4,
               32'h400, 4'b0100, 1'b0, 32'h0, 32'h000000B2);

      // Simultaneous fetch and load: data first, fetch after RESP, never overlapping.
      expect_bus(1'b0, 32'h500, 32'h0, 4'b1111);
      expect_bus(1'b0, 32'h104, 32'h0, 4'b1111);
      expect_done(1'b1, 32'h0BADC0DE, 1'b0);
      expect_done(1'b0, 32'h00000013, 1'b0);
      d_read = 1'b1; d_addr = 32'h500; if_req = 1'b1; if_addr = 32'h104;
      tick();
      check("sim_first_addr", mb.bus_addr, 32'h500);
      mb.bus_ack = 1'b1; mb.bus_rdata = 32'h0BADC0DE;
      tick();
      mb.bus_ack = 1'b0;
      check("sim_d_done", {30'd0, if_done, d_done}, 32'd1);
      check("sim_stall_fetch_pending", {31'd0, stall}, 32'd1);
      d_read = 1'b0;
      tick();
      check("sim_no_overlap", {31'd0, mb.bus_req}, 32'd0);
      tick();
      check("sim_fetch_req", {31'd0, mb.bus_req}, 32'd1);
      check("sim_fetch_addr", mb.bus_addr, 32'h104);
      mb.bus_ack = 1'b1; mb.bus_rdata = 32'h00000013;
      tick();
      mb.bus_ack = 1'b0;
      check("sim_if_done", {30'd0, if_done, d_done}, 32'd2);
      if_req = 1'b0;
      tick();

      // Reset while a load waits: no done, bus released, captured data cleared.
      expect_bus(1'b0, 32'h900, 32'h0, 4'b1111);
      d_read = 1'b1; d_addr = 32'h900;
      tick();
      tick();
      rst = 1'b1;
      tick();
      check("rstmid_bus_req", {31'd0, mb.bus_req}, 32'd0);
      check("rstmid_d_done", {31'd0, d_done}, 32'd0);
      check("rstmid_d_rdata", d_rdata, 32'h0);
      check("rstmid_if_rdata", if_rdata, 32'h0);
      rst = 1'b0; d_read = 1'b0;
      tick();
      mb.bus_ack = 1'b1; mb.bus_rdata = 32'h12121212;
      tick();
      mb.bus_ack = 1'b0;
      check("stray_ack_idle", {29'd0, mb.bus_req, if_done, d_done}, 32'd0);
      tick();

      run_xfer("fetch2",  1'b0, 1'b0, 1'b0, 1'b0, 32'h108, 32'h0, 1, 32'hFEEDFACE,
               32'h108, 4'b1111, 1'b0, 32'h0, 32'hFEEDFACE);
      run_xfer("lw2",     1'b1, 1'b1, 1'b0, 1'b0, 32'h600, 32'h0, 0, 32'h55AA55AA,
               32'h600, 4'b1111, 1'b0, 32'h0, 32'h55AA55AA);

      // Unanswered load: watchdog behaviour depends on the build.
      expect_bus(1'b0, 32'h700, 32'h0, 4'b1111);
      d_read = 1'b1; d_addr = 32'h700;
      tick();
`ifdef MEM_TIMEOUT_EN
      expect_done(1'b1, 32'h0, 1'b1);
      n = 0;
      while (mb.bus_req && n < 20) begin
         n++;
         tick();
      end
      check("tmo_wait_cycles", n, 32'd4);
      check("tmo_pulse", {30'd0, d_done, mb.bus_timeout}, 32'd3);
      d_read = 1'b0;
      tick();
      check("tmo_once", {30'd0, d_done, mb.bus_timeout}, 32'd0);
`else
      bad = 0;
      repeat (50) begin
         if (!mb.bus_req || mb.bus_timeout) bad++;
         tick();
      end
      check("no_tmo_hold", bad, 32'd0);
      expect_done(1'b1, 32'h00000077, 1'b0);
      mb.bus_ack = 1'b1; mb.bus_rdata = 32'h00000077;
      tick();
      mb.bus_ack = 1'b0;
      check("no_tmo_done", {30'd0, d_done, mb.bus_timeout}, 32'd2);
      d_read = 1'b0;
      tick();
`endif
      tick();
      check("bus_q_drained", bus_q.size(), 32'd0);
      check("done_q_drained", done_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
